// File: rtl/load_store_unit.sv
// Load/store unit: turns an ALU effective address into one handshaked data-bus
// transaction, formats load/store data and flags misaligned or timed-out accesses.
module load_store_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Address_i,
  input  logic [31:0] Store_Data_i,
  input  logic        Mem_Read_i,
  input  logic        Mem_Write_i,
  input  logic [2:0]  Funct3_i,
  output logic        Stall_o,
  output logic [31:0] Load_Data_o,
  output logic        Done_o,
  output logic        Misaligned_o,
  output logic        Bus_Error_o,
  output logic        Bus_Req_o,
  output logic        Bus_We_o,
  output logic [31:0] Bus_Addr_o,
  output logic [31:0] Bus_Wdata_o,
  output logic [3:0]  Bus_Be_o,
  input  logic [31:0] Bus_Rdata_i,
  input  logic        Bus_Ack_i
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, ld_q, ld_d, cnt_q, cnt_d;
  logic [3:0]  be_q, be_d;
  logic [2:0]  f3_q, f3_d;
  logic        we_q, we_d, mis_q, mis_d, err_q, err_d;
  logic        req_in, timeout_hit;

  // funct3[1:0] selects the size; the illegal codes 011/110/111 fall into W.
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] lane);
    case (f3[1:0])
      2'b00:   is_misaligned = 1'b0;
      2'b01:   is_misaligned = lane[0];
      default: is_misaligned = |lane;
    endcase
  endfunction

  function automatic logic [31:0] fmt_store(input logic [2:0] f3, input logic [31:0] d);
    case (f3[1:0])
      2'b00:   fmt_store = {4{d[7:0]}};
      2'b01:   fmt_store = {2{d[15:0]}};
      default: fmt_store = d;
    endcase
  endfunction

  function automatic logic [3:0] fmt_be(input logic [2:0] f3, input logic [1:0] lane);
    case (f3[1:0])
      2'b00:   fmt_be = 4'b0001 << lane;
      2'b01:   fmt_be = lane[1] ? 4'b1100 : 4'b0011;
      default: fmt_be = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] fmt_load(input logic [2:0] f3, input logic [1:0] lane,
                                           input logic [31:0] rdata);
    logic        [7:0]  b;
    logic        [15:0] h;
    logic signed [7:0]  sb;
    logic signed [15:0] sh;
    b  = 8'(rdata >> {lane, 3'b000});
    h  = lane[1] ? rdata[31:16] : rdata[15:0];
    sb = signed'(b);
    sh = signed'(h);
    case (f3[1:0])
      2'b00:   fmt_load = f3[2] ? {24'd0, b} : 32'(sb);
      2'b01:   fmt_load = f3[2] ? {16'd0, h} : 32'(sh);
      default: fmt_load = rdata;
    endcase
  endfunction

  assign req_in      = Mem_Read_i | Mem_Write_i;
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == 32'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    f3_d    = f3_q;
    we_d    = we_q;
    mis_d   = mis_q;
    err_d   = err_q;
    ld_d    = ld_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (req_in) begin
          addr_d  = Address_i;
          f3_d    = Funct3_i;
          we_d    = Mem_Write_i;
          wdata_d = fmt_store(Funct3_i, Store_Data_i);
          be_d    = fmt_be(Funct3_i, Address_i[1:0]);
          mis_d   = is_misaligned(Funct3_i, Address_i[1:0]);
          err_d   = 1'b0;
          ld_d    = 32'd0;
          cnt_d   = 32'd0;
          state_d = mis_d ? DONE : BUSY;
        end
      end
      BUSY: begin
        // An ack coinciding with the last timeout cycle still completes normally.
        if (Bus_Ack_i) begin
          ld_d    = we_q ? 32'd0 : fmt_load(f3_q, addr_q[1:0], Bus_Rdata_i);
          state_d = DONE;
        end else if (timeout_hit) begin
          err_d   = 1'b1;
          ld_d    = 32'd0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      f3_q    <= '0;
      we_q    <= 1'b0;
      mis_q   <= 1'b0;
      err_q   <= 1'b0;
      ld_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      f3_q    <= f3_d;
      we_q    <= we_d;
      mis_q   <= mis_d;
      err_q   <= err_d;
      ld_q    <= ld_d;
      cnt_q   <= cnt_d;
    end
  end

  assign Stall_o      = ((state_q == IDLE) && req_in) || (state_q == BUSY);
  assign Done_o       = (state_q == DONE);
  assign Misaligned_o = Done_o & mis_q;
  assign Bus_Error_o  = Done_o & err_q;
  assign Load_Data_o  = Done_o ? ld_q : 32'd0;
  assign Bus_Req_o    = (state_q == BUSY);
  assign Bus_We_o     = Bus_Req_o & we_q;
  assign Bus_Be_o     = Bus_Req_o ? be_q : 4'b0000;
  assign Bus_Addr_o   = {addr_q[31:2], 2'b00};
  assign Bus_Wdata_o  = wdata_q;

endmodule
